// File: rtl/operand_fetch_4b_pkg.sv
// Shared constants for the 4-bit operand stage and the 4-bit logic units.
package operand_fetch_4b_pkg;

    localparam int unsigned OF_WIDTH = 4;
    localparam int unsigned OF_NREGS = 4;
    localparam int unsigned OF_AW    = 2;

    // Index of the hardwired-zero register.
    localparam logic [OF_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/operand_fetch_4b_if.sv
// Write port, read request and operand handshake of the operand fetch stage.
interface operand_fetch_4b_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned AW    = 2
);

    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    raddr_x;
    logic [AW-1:0]    raddr_y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;

    // Requesting side: drives writes, read requests and the consume strobe.
    modport master (
        output we, waddr, wdata, in_valid, raddr_x, raddr_y, out_ready,
        input  in_ready, out_valid, x, y
    );

    // Operand stage side.
    modport slave (
        input  we, waddr, wdata, in_valid, raddr_x, raddr_y, out_ready,
        output in_ready, out_valid, x, y
    );

endinterface

// File: rtl/operand_fetch_4b_regfile_core.sv
// Register file: one write port, two combinational read ports, register 0 reads zero.
module regfile_core
    import operand_fetch_4b_pkg::*;
#(
    parameter int unsigned WIDTH = OF_WIDTH,
    parameter int unsigned NREGS = OF_NREGS,
    parameter int unsigned AW    = OF_AW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_x,
    input  logic [AW-1:0]    raddr_y,
    output logic [WIDTH-1:0] rdata_x,
    output logic [WIDTH-1:0] rdata_y
);

    logic [WIDTH-1:0] mem [NREGS];

    // Storage update; writes to register 0 are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem <= '{default: '0};
        end else if (we && (waddr != REG_ZERO)) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports with register 0 forced to zero.
    always_comb begin
        rdata_x = (raddr_x == REG_ZERO) ? '0 : mem[raddr_x];
        rdata_y = (raddr_y == REG_ZERO) ? '0 : mem[raddr_y];
    end

endmodule

// File: rtl/operand_fetch_4b.sv
// Operand fetch stage: reads two registers per request and holds them as x/y
// behind a valid/ready handshake, with write-to-read bypass.
module operand_fetch_4b
    import operand_fetch_4b_pkg::*;
#(
    parameter int unsigned WIDTH = OF_WIDTH,
    parameter int unsigned NREGS = OF_NREGS,
    parameter int unsigned AW    = OF_AW
) (
    input  logic                 clk,
    input  logic                 reset,
    operand_fetch_4b_if.slave    bus
);

    logic [WIDTH-1:0] rdata_x;
    logic [WIDTH-1:0] rdata_y;
    logic [WIDTH-1:0] next_x;
    logic [WIDTH-1:0] next_y;
    logic             wr_hit;
    logic             accept;
    logic             out_valid_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;

    regfile_core #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (bus.we),
        .waddr   (bus.waddr),
        .wdata   (bus.wdata),
        .raddr_x (bus.raddr_x),
        .raddr_y (bus.raddr_y),
        .rdata_x (rdata_x),
        .rdata_y (rdata_y)
    );

    // Handshake and per-port bypass of a same-cycle write to a non-zero register.
    always_comb begin
        bus.in_ready = !out_valid_q || bus.out_ready;
        accept       = bus.in_valid && bus.in_ready;
        wr_hit       = bus.we && (bus.waddr != REG_ZERO);
        next_x       = (wr_hit && (bus.raddr_x == bus.waddr)) ? bus.wdata : rdata_x;
        next_y       = (wr_hit && (bus.raddr_y == bus.waddr)) ? bus.wdata : rdata_y;
    end

    // Operand registers: load on accept, drop valid on consume, hold on stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q         <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            x_q         <= next_x;
            y_q         <= next_y;
            out_valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.x         = x_q;
    assign bus.y         = y_q;

endmodule

// File: tb/tb_operand_fetch_4b.sv
// Directed bench for operand_fetch_4b.
module tb_operand_fetch_4b;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    operand_fetch_4b_if #(.WIDTH(4), .AW(2)) bus ();

    operand_fetch_4b #(
        .WIDTH (4),
        .NREGS (4),
        .AW    (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle();
        bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
        bus.in_valid = 1'b0; bus.raddr_x = '0; bus.raddr_y = '0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d);
        bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
        cyc();
        bus.we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.we = 1'b1; bus.waddr = 2'd1; bus.wdata = 4'hF;
        bus.in_valid = 1'b1; bus.raddr_x = 2'd1; bus.raddr_y = 2'd1;
        bus.out_ready = 1'b0;
        cyc();
        cyc();
        chk("reset_out_valid", {3'b0, bus.out_valid}, 4'h0);
        chk("reset_x", bus.x, 4'h0);
        chk("reset_y", bus.y, 4'h0);
        chk("reset_in_ready", {3'b0, bus.in_ready}, 4'h1);
        reset = 1'b0;
        idle();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.raddr_x = 2'd1; bus.raddr_y = 2'd1;
        cyc();
        idle();
        chk("reset_no_write_valid", {3'b0, bus.out_valid}, 4'h1);
        chk("reset_no_write_r1", bus.x, 4'h0);
        cyc();
        chk("reset_drain", {3'b0, bus.out_valid}, 4'h0);
    endtask

    task automatic test_basic_read();
        wr(2'd1, 4'b1000);
        wr(2'd2, 4'b1001);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.raddr_x = 2'd1; bus.raddr_y = 2'd2;
        cyc();
        idle();
        chk("basic_valid", {3'b0, bus.out_valid}, 4'h1);
        chk("basic_x", bus.x, 4'b1000);
        chk("basic_y", bus.y, 4'b1001);
        chk("basic_and", bus.x & bus.y, 4'b1000);
        cyc();
        chk("consume_valid", {3'b0, bus.out_valid}, 4'h0);
        chk("consume_x_hold", bus.x, 4'b1000);
    endtask

    task automatic test_bypass();
        wr(2'd3, 4'b0011);
        bus.out_ready = 1'b1;
        bus.we = 1'b1; bus.waddr = 2'd3; bus.wdata = 4'b0110;
        bus.in_valid = 1'b1; bus.raddr_x = 2'd1; bus.raddr_y = 2'd3;
        cyc();
        idle();
        chk("bypass_x", bus.x, 4'b1000);
        chk("bypass_y", bus.y, 4'b0110);
        bus.we = 1'b1; bus.waddr = 2'd3; bus.wdata = 4'b1010;
        bus.in_valid = 1'b1; bus.raddr_x = 2'd3; bus.raddr_y = 2'd3;
        cyc();
        idle();
        chk("bypass_both_x", bus.x, 4'b1010);
        chk("bypass_both_y", bus.y, 4'b1010);
        cyc();
    endtask

    task automatic test_r0();
        wr(2'd0, 4'b1111);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.raddr_x = 2'd0; bus.raddr_y = 2'd0;
        cyc();
        idle();
        chk("r0_valid", {3'b0, bus.out_valid}, 4'h1);
        chk("r0_x", bus.x, 4'h0);
        chk("r0_y", bus.y, 4'h0);
        bus.we = 1'b1; bus.waddr = 2'd0; bus.wdata = 4'b1111;
        bus.in_valid = 1'b1; bus.raddr_x = 2'd0; bus.raddr_y = 2'd3;
        cyc();
        idle();
        chk("r0_no_bypass_x", bus.x, 4'h0);
        chk("r0_no_bypass_y", bus.y, 4'b1010);
        cyc();
    endtask

    task automatic test_stall();
        wr(2'd1, 4'b1101);
        wr(2'd2, 4'b0110);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.raddr_x = 2'd1; bus.raddr_y = 2'd2;
        cyc();
        bus.raddr_x = 2'd2; bus.raddr_y = 2'd2;
        bus.we = 1'b1; bus.waddr = 2'd1; bus.wdata = 4'b0001;
        chk("stall_in_ready", {3'b0, bus.in_ready}, 4'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            bus.we = 1'b0;
            chk("stall_valid", {3'b0, bus.out_valid}, 4'h1);
            chk("stall_x", bus.x, 4'b1101);
            chk("stall_y", bus.y, 4'b0110);
            chk("stall_in_ready_hold", {3'b0, bus.in_ready}, 4'h0);
        end
        idle();
        bus.out_ready = 1'b1;
        #1;
        chk("unstall_in_ready", {3'b0, bus.in_ready}, 4'h1);
        cyc();
        chk("unstall_valid", {3'b0, bus.out_valid}, 4'h0);
        chk("unstall_x_hold", bus.x, 4'b1101);
        bus.in_valid = 1'b1; bus.raddr_x = 2'd1; bus.raddr_y = 2'd1;
        cyc();
        idle();
        chk("stall_write_landed", bus.x, 4'b0001);
        cyc();
    endtask

    task automatic test_streaming();
        logic [1:0] ax [4];
        logic [1:0] ay [4];
        logic [3:0] ex [4];
        logic [3:0] ey [4];
        wr(2'd1, 4'b0101);
        wr(2'd2, 4'b1100);
        wr(2'd3, 4'b0111);
        ax = '{2'd1, 2'd2, 2'd3, 2'd1};
        ay = '{2'd2, 2'd3, 2'd1, 2'd1};
        ex = '{4'b0101, 4'b1100, 4'b0111, 4'b0101};
        ey = '{4'b1100, 4'b0111, 4'b0101, 4'b0101};
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.raddr_x = ax[i]; bus.raddr_y = ay[i];
            chk("stream_in_ready", {3'b0, bus.in_ready}, 4'h1);
            cyc();
            chk("stream_valid", {3'b0, bus.out_valid}, 4'h1);
            chk("stream_x", bus.x, ex[i]);
            chk("stream_y", bus.y, ey[i]);
        end
        idle();
        cyc();
        chk("stream_drain", {3'b0, bus.out_valid}, 4'h0);
    endtask

    task automatic test_reset_pending();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.raddr_x = 2'd2; bus.raddr_y = 2'd3;
        cyc();
        idle();
        chk("pending_valid", {3'b0, bus.out_valid}, 4'h1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("pending_dropped", {3'b0, bus.out_valid}, 4'h0);
        chk("pending_x_clear", bus.x, 4'h0);
        bus.in_valid = 1'b1; bus.raddr_x = 2'd2; bus.raddr_y = 2'd3;
        cyc();
        idle();
        chk("pending_regs_clear_x", bus.x, 4'h0);
        chk("pending_regs_clear_y", bus.y, 4'h0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        bus.out_ready = 1'b0;
        idle();
        test_reset();
        test_basic_read();
        test_bypass();
        test_r0();
        test_stall();
        test_streaming();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
